// File: rtl/fifo_rd_stream.sv
// Pulls words from a 1-cycle-latency FIFO into a 2-entry skid buffer and presents them as a valid/ready stream.
// Latency: data are valid 2 cycles after fifo_empty falls. Backpressure: reads stop once buffered plus in-flight words reach 2.
module fifo_rd_stream #(
    parameter int DW   = 16,
    parameter int CNTW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fifo_empty,
    input  logic [DW-1:0]   fifo_rd_data,
    input  logic            fifo_rd_valid,
    output logic            fifo_rd_en,
    output logic [DW-1:0]   out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CNTW-1:0] occupancy,
    output logic            err
);

    logic [DW-1:0]   r_entry [2];
    logic            r_head;
    logic            r_tail;
    logic [CNTW-1:0] r_occ;
    logic            r_inflight;
    logic            r_run;
    logic            r_err;

    logic            w_pop;
    logic [2:0]      w_sum;
    logic            w_rdv;
    logic            w_unsol;
    logic            w_ovf;
    logic            w_push;

    assign out_valid = (r_occ != '0);
    assign out_data  = r_entry[r_head];
    assign occupancy = r_occ;
    assign err       = r_err;

    assign w_pop = out_valid & out_ready;
    assign w_sum = 3'(r_occ) + 3'(r_inflight) - 3'(w_pop);

    // r_run holds reads off (and masks stray strobes) for the first cycle after reset release.
    assign fifo_rd_en = r_run & ~fifo_empty & (w_sum < 3'd2);

    assign w_rdv   = fifo_rd_valid & r_run;
    assign w_unsol = w_rdv & ~r_inflight;
    assign w_ovf   = w_rdv & r_inflight & (r_occ == CNTW'(2)) & ~w_pop;
    assign w_push  = w_rdv & r_inflight & ~w_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
            r_occ      <= '0;
            r_inflight <= 1'b0;
            r_run      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_run      <= 1'b1;
            r_inflight <= fifo_rd_en;
            r_err      <= r_err | w_unsol | w_ovf;
            if (w_pop) begin
                r_head <= ~r_head;
            end
            if (w_push) begin
                r_tail <= ~r_tail;
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + CNTW'(1);
            end else if (w_pop && !w_push) begin
                r_occ <= r_occ - CNTW'(1);
            end
        end
    end

    // On push+pop at full, tail equals head, so the new word lands in the slot being freed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_entry[0] <= '0;
            r_entry[1] <= '0;
        end else if (w_push) begin
            r_entry[r_tail] <= fifo_rd_data;
        end
    end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Downstream read-side adapter for the synchronous FIFO.
- Converts the FIFO's pull interface into a valid/ready stream for consumers that may stall arbitrarily:
  - FIFO side: rd_en/empty, with a 1-cycle read latency and a rd_valid strobe.
  - Consumer side: out_valid/out_ready.
- Holds a 2-entry skid buffer so that no data are lost and one word per cycle is sustained when the consumer is always ready.
- Sits between the FIFO read port and any stream consumer, in the same clock domain.

Parameters:
- DW, 16, data width; must equal the FIFO data width.
- CNTW, 2, occupancy counter width; fixed. Holds 0..2.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_data  input  DW  FIFO read data; sampled only when fifo_rd_valid=1.
- fifo_rd_valid  input  1  FIFO read-data strobe; arrives 1 cycle after an accepted rd_en.
- fifo_rd_en  output  1  read request to the FIFO; registered-free, combinational from state.
- out_data  output  DW  stream data (head of the skid buffer).
- out_valid  output  1  stream valid.
- out_ready  input  1  consumer ready.
- occupancy  output  CNTW  number of words held in the skid buffer (0..2).
- err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (rst_n low, asynchronous assertion, synchronous-clean release):
  - occupancy=0, inflight=0, out_valid=0, err=0, fifo_rd_en=0.
  - out_data=0; buffer contents are don't-care.
- Buffer: 2-entry circular store with 1-bit head and tail pointers plus occupancy.
  - out_valid = (occupancy != 0).
  - out_data = entry[head].
- pop = out_valid & out_ready. On pop, head toggles.
- inflight register: set to fifo_rd_en each cycle. It means one word is due on fifo_rd_valid next cycle.
- Issue rule:
  - fifo_rd_en = !fifo_empty & ((occupancy + inflight - pop) < 2).
  - Arithmetic is 3 bits wide, no wrap.
  - fifo_rd_en is never asserted while fifo_empty=1, so every issued request is accepted by the FIFO.
- Push: on fifo_rd_valid, entry[tail] <= fifo_rd_data, and tail toggles.
- occupancy update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push and pop at occupancy 2 is legal only if the issue rule was obeyed. In that case the new word goes to the slot freed by the pop (tail==head before the toggle).
- Throughput: with out_ready held high, the steady state is occupancy=1, inflight=1, giving 1 word/cycle.
- Latency: a word written into an empty FIFO appears at out_valid 2 cycles after fifo_empty deasserts: 1 cycle for the FIFO read plus 1 cycle of registered buffer.
- Stall: if out_ready is low, at most 2 words are held and fifo_rd_en drops once occupancy + inflight reaches 2.
- Stream rule: once out_valid=1, out_data must stay stable until pop.
- err is set and held until reset on either of:
  - fifo_rd_valid=1 while inflight=0 (unsolicited data);
  - push while occupancy=2 and no pop (overflow). The push is dropped and state is unchanged.
- Missing data: inflight=1 with no fifo_rd_valid is not an error. inflight simply clears, which tolerates a FIFO reset.
- Reset mid-operation: words in flight are discarded and any fifo_rd_valid in the first cycle after release is ignored without setting err.

Test Plan:
- Reset, then write 0x0001..0x0008 into the FIFO, out_ready=1 → out_data 0x0001..0x0008 on 8 consecutive cycles with no gaps; first word 2 cycles after fifo_empty falls; occupancy ≤ 2; err=0.
- Same 8 words with out_ready=0 for 10 cycles, then 1 → fifo_rd_en pulses exactly twice then stays low; occupancy=2 and out_data=0x0001 held stable; on release the sequence is in order with no loss or duplicate.
- out_ready toggled every cycle with a continuous supply (0xA000+n) → every word delivered exactly once, in order; no cycle with fifo_rd_en=1 while fifo_empty=1.
- Single word 0x1234 into an empty FIFO, out_ready=1 → one out_valid pulse carrying 0x1234; afterwards fifo_rd_en=0 and out_valid=0.
- Force fifo_rd_valid=1 with no preceding fifo_rd_en → err=1 and stays 1; occupancy unchanged; err clears only on rst_n low.
- Assert rst_n low mid-stream at occupancy 2 → outputs go to reset values immediately, without waiting for clk; after release, stream restarts cleanly from the FIFO's next word.
